// File: rtl/streamlined_divider_nbit.sv
// Restoring shift-subtract divider, one quotient bit per clock, MSB first.
// Define SIGNED_DIV_EN for two's-complement operands; the default build is unsigned.
module streamlined_divider_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_sig,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done_sig,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CALC   = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam int             CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem_work;
    logic [WIDTH-1:0] quo_work;
    logic [WIDTH-1:0] div_work;
    logic             zero_div;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] quo_result;
    logic [WIDTH-1:0] rem_result;

    assign busy    = (state != IDLE);
    assign shifted = (rem_work << 1) | {{WIDTH{1'b0}}, quo_work[WIDTH-1]};
    assign trial   = shifted - {1'b0, div_work};
    assign fits    = (shifted >= {1'b0, div_work});

    // With a zero divisor no CALC cycles run, so quo_work still holds the dividend magnitude.
    assign rem_mag = zero_div ? quo_work : rem_work[WIDTH-1:0];

`ifdef SIGNED_DIV_EN
    logic neg_quo;
    logic neg_rem;

    assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign quo_result   = zero_div ? '1 : (neg_quo ? -quo_work : quo_work);
    assign rem_result   = neg_rem ? -rem_mag : rem_mag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
        end else if (state == IDLE && start_sig) begin
            neg_quo <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem <= dividend[WIDTH-1];
        end
    end
`else
    assign dividend_mag = dividend;
    assign divisor_mag  = divisor;
    assign quo_result   = zero_div ? '1 : quo_work;
    assign rem_result   = rem_mag;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            rem_work    <= '0;
            quo_work    <= '0;
            div_work    <= '0;
            zero_div    <= 1'b0;
            done_sig    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done_sig <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_sig) begin
                        quo_work <= dividend_mag;
                        div_work <= divisor_mag;
                        rem_work <= '0;
                        count    <= '0;
                        zero_div <= (divisor == '0);
                        state    <= (divisor == '0) ? FINISH : CALC;
                    end
                end
                CALC: begin
                    if (fits) begin
                        rem_work <= trial;
                        quo_work <= {quo_work[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_work <= shifted;
                        quo_work <= {quo_work[WIDTH-2:0], 1'b0};
                    end
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    quotient    <= quo_result;
                    remainder   <= rem_result;
                    div_by_zero <= zero_div;
                    done_sig    <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
